sar_ctrl: RTL and testbench

Successive-approximation controller for the SAR ADC. It is the consumer side of the one-hot pulse sequencing: it generates its own MSB-to-LSB one-hot bit-trial sequence and drives the DAC trial code. It takes the comparator decision on each trial and assembles the final conversion word. It sits between the capacitive DAC / comparator front end and the digital readout, with a start/valid handshake toward the readout.

---
 rtl/sar_ctrl.sv | 131 +++++++++++++
 tb/tb_sar_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sar_ctrl.sv
// Successive-approximation controller: samples, walks a one-hot MSB-to-LSB trial
// over the DAC code, keeps bits on comparator decisions and publishes the result.
module sar_ctrl #(
    parameter int N_BITS        = 10,
    parameter int SAMPLE_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_cmp,
    output logic              o_sample,
    output logic              o_busy,
    output logic [N_BITS-1:0] o_taps,
    output logic [N_BITS-1:0] o_dac,
    output logic [N_BITS-1:0] o_data,
    output logic              o_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0]        CNT_INIT = 4'(SAMPLE_CYCLES - 1);
    localparam logic [N_BITS-1:0] MSB_BIT  = {1'b1, {(N_BITS-1){1'b0}}};

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [N_BITS-1:0] taps_q, taps_d;
    logic [N_BITS-1:0] dac_q, dac_d;
    logic [N_BITS-1:0] data_q, data_d;
    logic              sample_q, sample_d;
    logic              busy_q, busy_d;
    logic              valid_q, valid_d;
    logic [N_BITS-1:0] kept;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        taps_d   = taps_q;
        dac_d    = dac_q;
        data_d   = data_q;
        sample_d = sample_q;
        busy_d   = busy_q;
        valid_d  = 1'b0;
        // Trial bit survives only if the comparator says Vin >= Vdac.
        kept     = i_cmp ? dac_q : (dac_q & ~taps_q);

        case (state_q)
            IDLE: begin
                taps_d   = '0;
                dac_d    = '0;
                sample_d = 1'b0;
                busy_d   = 1'b0;
                if (i_start) begin
                    state_d  = SAMPLE;
                    cnt_d    = CNT_INIT;
                    sample_d = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            SAMPLE: begin
                if (cnt_q == 4'd0) begin
                    state_d  = CONVERT;
                    sample_d = 1'b0;
                    taps_d   = MSB_BIT;
                    dac_d    = MSB_BIT;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CONVERT: begin
                if (taps_q[0]) begin
                    state_d = DONE;
                    taps_d  = '0;
                    dac_d   = kept;
                    data_d  = kept;
                    valid_d = 1'b1;
                end else begin
                    taps_d = taps_q >> 1;
                    dac_d  = kept | (taps_q >> 1);
                end
            end
            DONE: begin
                state_d = IDLE;
                dac_d   = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d  = IDLE;
                taps_d   = '0;
                dac_d    = '0;
                sample_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // Reset clears the published result as well as control, aborting any conversion.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            taps_q   <= '0;
            dac_q    <= '0;
            data_q   <= '0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            taps_q   <= taps_d;
            dac_q    <= dac_d;
            data_q   <= data_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
        end
    end

    assign o_sample = sample_q;
    assign o_busy   = busy_q;
    assign o_taps   = taps_q;
    assign o_dac    = dac_q;
    assign o_data   = data_q;
    assign o_valid  = valid_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// Directed bench for sar_ctrl with an ideal comparator model (cmp = V >= o_dac).
module tb_sar_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       cmp;
    logic       sample;
    logic       busy;
    logic [9:0] taps;
    logic [9:0] dac;
    logic [9:0] data;
    logic       valid;
    logic [9:0] v_in;

    int n_checks;
    int n_err;
    int n_valid;
    int vbase;

    logic [9:0] mid_tbl [10] = '{10'h200, 10'h300, 10'h280, 10'h2C0, 10'h2A0,
                                 10'h2B0, 10'h2A8, 10'h2AC, 10'h2AA, 10'h2AB};

    sar_ctrl #(.N_BITS(10), .SAMPLE_CYCLES(2)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_start  (start),
        .i_cmp    (cmp),
        .o_sample (sample),
        .o_busy   (busy),
        .o_taps   (taps),
        .o_dac    (dac),
        .o_data   (data),
        .o_valid  (valid)
    );

    assign cmp = (v_in >= dac);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (valid === 1'b1) n_valid++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sample"}, 32'(sample), 32'd0);
        check({tag, "_busy"},   32'(busy),   32'd0);
        check({tag, "_taps"},   32'(taps),   32'd0);
        check({tag, "_dac"},    32'(dac),    32'd0);
        check({tag, "_valid"},  32'(valid),  32'd0);
    endtask

    // mode 0: no dac check, 1: mid-scale table, 2: dac equals taps
    task automatic run_conv(input logic [9:0] v, input logic [9:0] exp, input int mode,
                            input string tag);
        int nv0;
        nv0   = n_valid;
        v_in  = v;
        start = 1'b1;
        tick();                                   // cycle 1
        start = 1'b0;
        check({tag, "_c1_sample"}, 32'(sample), 32'd1);
        check({tag, "_c1_busy"},   32'(busy),   32'd1);
        check({tag, "_c1_taps"},   32'(taps),   32'd0);
        tick();                                   // cycle 2
        check({tag, "_c2_sample"}, 32'(sample), 32'd1);
        for (int k = 9; k >= 0; k--) begin
            tick();                               // cycles 3..12
            check({tag, "_taps"},   32'(taps),   32'(10'h001 << k));
            check({tag, "_sample"}, 32'(sample), 32'd0);
            if (mode == 1) check({tag, "_dac"}, 32'(dac), 32'(mid_tbl[9-k]));
            if (mode == 2) check({tag, "_dac_eq_taps"}, 32'(dac), 32'(10'h001 << k));
        end
        tick();                                   // cycle 13
        check({tag, "_c13_valid"}, 32'(valid), 32'd1);
        check({tag, "_c13_data"},  32'(data),  32'(exp));
        check({tag, "_c13_taps"},  32'(taps),  32'd0);
        check({tag, "_c13_dac"},   32'(dac),   32'(exp));
        check({tag, "_c13_busy"},  32'(busy),  32'd1);
        tick();                                   // cycle 14
        check_idle({tag, "_c14"});
        check({tag, "_c14_data"},   32'(data),    32'(exp));
        check({tag, "_valid_cnt"},  32'(n_valid), 32'(nv0 + 1));
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        n_valid  = 0;
        rst      = 1'b1;
        start    = 1'b1;
        v_in     = '0;

        // reset held two edges with start asserted
        tick();
        tick();
        check_idle("rst");
        check("rst_data", 32'(data), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        tick();
        tick();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_sample", 32'(sample), 32'd0);

        run_conv(10'h2AA, 10'h2AA, 1, "mid");
        run_conv(10'h3FF, 10'h3FF, 0, "max");
        run_conv(10'h000, 10'h000, 2, "zero");

        // start pulses in SAMPLE, mid-CONVERT and DONE
        vbase = n_valid;
        v_in  = 10'h1C3;
        start = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            tick();
            start = (c == 1) || (c == 7) || (c == 13);
            check("busy_start_valid", 32'(valid), 32'(c == 13));
            if (c == 13) check("busy_start_data", 32'(data), 32'h1C3);
            if (c >= 14) check("busy_start_busy", 32'(busy), 32'd0);
        end
        start = 1'b0;
        check("busy_start_cnt", 32'(n_valid), 32'(vbase + 1));

        // reset while o_taps = 0x020
        vbase = n_valid;
        v_in  = 10'h155;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 2; c <= 7; c++) tick();
        check("rmid_taps", 32'(taps), 32'h020);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle("rmid");
        check("rmid_data", 32'(data), 32'd0);
        tick();
        tick();
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_novalid", 32'(n_valid), 32'(vbase));
        run_conv(10'h155, 10'h155, 0, "after_rst");

        // back-to-back with start held high
        v_in  = 10'h0F0;
        start = 1'b1;
        for (int c = 1; c <= 28; c++) begin
            tick();
            check("b2b_valid", 32'(valid), 32'((c == 13) || (c == 27)));
            if (c >= 13 && c <= 26) check("b2b_data0", 32'(data), 32'h0F0);
            if (c == 27) check("b2b_data1", 32'(data), 32'h30F);
            if (c == 15) check("b2b_restart", 32'(sample), 32'd1);
            if (c == 13) v_in = 10'h30F;
            if (c == 20) start = 1'b0;
        end
        check("b2b_end_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
